// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit: FSM states,
// datapath select codes, ALU operation codes, condition codes and the per-state control bundle.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic       next_pc;
        logic       ir_write;
        logic       adr_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res_src;
    } ctl_t;

    // Raw controls asserted in each state, before condition gating.
    function automatic ctl_t state_ctl(state_e s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1;
                c.next_pc  = 1'b1;
                c.src_a    = SRCA_PC;
                c.src_b    = SRCB_FOUR;
                c.res_src  = RES_ALURESULT;
            end
            S_DECODE: begin
                c.src_a   = SRCA_PC;
                c.src_b   = SRCB_FOUR;
                c.res_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                c.src_a = SRCA_RD1;
                c.src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.adr_src = 1'b1;
                c.res_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.res_src = RES_DATA;
                c.reg_w   = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src = 1'b1;
                c.res_src = RES_ALUOUT;
                c.mem_w   = 1'b1;
            end
            S_EXECR: begin
                c.src_a  = SRCA_RD1;
                c.src_b  = SRCB_RD2;
                c.alu_op = 1'b1;
            end
            S_EXECI: begin
                c.src_a  = SRCA_RD1;
                c.src_b  = SRCB_IMM;
                c.alu_op = 1'b1;
            end
            S_ALUWB: begin
                c.res_src = RES_ALUOUT;
                c.reg_w   = 1'b1;
            end
            S_BRANCH: begin
                c.src_a   = SRCA_ALUOUT;
                c.src_b   = SRCB_IMM;
                c.res_src = RES_ALURESULT;
                c.branch  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decoder: maps the data-processing cmd field to an ALU operation
// and decides which flag halves an S-suffixed instruction may update.
module alu_dec
    import ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic [1:0] flag_w
);

    logic add_sub;

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        add_sub     = 1'b0;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: begin alu_control = ALU_ADD; add_sub = 1'b1; end
                4'b0010: begin alu_control = ALU_SUB; add_sub = 1'b1; end
                4'b0000: alu_control = ALU_AND;
                4'b1100: alu_control = ALU_ORR;
                4'b0001: alu_control = ALU_EOR;
                default: alu_control = ALU_ADD;
            endcase
            // C and V only carry meaning for arithmetic operations.
            flag_w = {funct[0], funct[0] & add_sub};
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, flags register and condition check.
// Define PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counters.
//
//   state  | meaning
//   FETCH  | load IR, PC <= PC+4
//   DECODE | read registers, form PC+8; dispatch on Op
//   MEMADR | compute load/store address
//   MEMRD  | read data memory
//   MEMWB  | write loaded data to register file
//   MEMWR  | write data memory
//   EXECR  | data-processing, register operand
//   EXECI  | data-processing, immediate operand
//   ALUWB  | write ALU result to register file
//   BRANCH | compute branch target, load PC
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_e     state_q, state_d;
    ctl_t       ctl_q, ctl_d, cur;
    logic [3:0] flags_q, flags_d;
    logic [1:0] flag_w;
    logic       cond_ex, pcs;
    logic       n_f, z_f, c_f, v_f;

    // Selects show FETCH values while reset is held, even in the first reset cycle.
    assign cur = reset ? state_ctl(S_FETCH) : ctl_q;

    alu_dec u_alu_dec (
        .alu_op      (cur.alu_op),
        .funct       (Funct),
        .alu_control (ALUControl),
        .flag_w      (flag_w)
    );

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = ~(n_f ^ v_f);
            COND_LT: cond_ex = n_f ^ v_f;
            COND_GT: cond_ex = ~z_f & ~(n_f ^ v_f);
            COND_LE: cond_ex = z_f | (n_f ^ v_f);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
        ctl_d = state_ctl(state_d);

        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && cond_ex) begin
            if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctl_q   <= state_ctl(S_FETCH);
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            flags_q <= flags_d;
        end
    end

    assign pcs       = ((Rd == 4'hF) & cur.reg_w) | cur.branch;
    assign PCWrite   = ~reset & (cur.next_pc | (pcs & cond_ex));
    assign RegWrite  = ~reset & cur.reg_w & cond_ex;
    assign MemWrite  = ~reset & cur.mem_w & cond_ex;
    assign IRWrite   = ~reset & cur.ir_write;
    assign AdrSrc    = cur.adr_src;
    assign ALUSrcA   = cur.src_a;
    assign ALUSrcB   = cur.src_b;
    assign ResultSrc = cur.res_src;
    assign RegSrc    = {Op == 2'b01, Op == 2'b10};
    assign ImmSrc    = Op;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Every path into FETCH leaves a terminal state, so any non-FETCH -> FETCH step retires one instruction.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        instr_cnt_d = instr_cnt_q;
        if (state_d == S_FETCH && state_q != S_FETCH)
            instr_cnt_d = instr_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level reference model pushes the expected
// per-cycle control outputs into a queue; a monitor on the falling edge pops and compares.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] regsrc;
        logic [1:0] immsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [2:0] aluctl;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Cond = 4'hE;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'd0;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0] RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ALUControl;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
    int          m_cycles = 0;
    int          m_instrs = 0;
`endif

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    obs_t       exp_q[$];
    obs_t       seq[$];
    logic [3:0] mflags = 4'b0000;
    int         checks = 0;
    int         errors = 0;

    function automatic logic cond_holds(logic [3:0] c, logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b0;
        endcase
        return base ^ c[0];
    endfunction

    function automatic obs_t rec(logic [1:0] op, logic [1:0] a, logic [1:0] b, logic [1:0] r);
        obs_t o;
        o        = '0;
        o.regsrc = {op == 2'b01, op == 2'b10};
        o.immsrc = op;
        o.srca   = a;
        o.srcb   = b;
        o.res    = r;
        return o;
    endfunction

    // Instruction-level model: builds the whole expected cycle sequence into seq and updates mflags.
    task automatic build(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd, input logic [3:0] alf);
        obs_t o;
        logic ce;
        logic [2:0] ctl;
        seq.delete();
        o = rec(op, 2'b01, 2'b10, 2'b10); o.pcw = 1'b1; o.irw = 1'b1;
        seq.push_back(o);
        seq.push_back(rec(op, 2'b01, 2'b10, 2'b10));
        if (op == 2'b10) begin
            o = rec(op, 2'b10, 2'b01, 2'b10); o.pcw = cond_holds(c, mflags);
            seq.push_back(o);
        end else if (op == 2'b01) begin
            ce = cond_holds(c, mflags);
            seq.push_back(rec(op, 2'b00, 2'b01, 2'b00));
            if (f[0]) begin
                o = rec(op, 2'b00, 2'b00, 2'b00); o.adr = 1'b1;
                seq.push_back(o);
                o = rec(op, 2'b00, 2'b00, 2'b01); o.regw = ce; o.pcw = ce && (rd == 4'hF);
                seq.push_back(o);
            end else begin
                o = rec(op, 2'b00, 2'b00, 2'b00); o.adr = 1'b1; o.memw = ce;
                seq.push_back(o);
            end
        end else if (op == 2'b00) begin
            case (f[4:1])
                4'b0010: ctl = 3'b001;
                4'b0000: ctl = 3'b010;
                4'b1100: ctl = 3'b011;
                4'b0001: ctl = 3'b100;
                default: ctl = 3'b000;
            endcase
            o = rec(op, 2'b00, f[5] ? 2'b01 : 2'b00, 2'b00); o.aluctl = ctl;
            seq.push_back(o);
            if (cond_holds(c, mflags) && f[0]) begin
                mflags[3:2] = alf[3:2];
                if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) mflags[1:0] = alf[1:0];
            end
            ce = cond_holds(c, mflags);
            o = rec(op, 2'b00, 2'b00, 2'b00); o.regw = ce; o.pcw = ce && (rd == 4'hF);
            seq.push_back(o);
        end
    endtask

    // Called at posedge+1 of a FETCH cycle; runs the instruction, or only its first stop_after cycles.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic [3:0] alf, input int stop_after);
        int n;
`ifdef PERF_CNT_EN
        checks++;
        if (instr_cnt !== 32'(m_instrs) || cycle_cnt !== 32'(m_cycles)) begin
            errors++;
            $display("FAIL perf_cnt instr_cnt=%0d cycle_cnt=%0d required instr=%0d cycle=%0d",
                     instr_cnt, cycle_cnt, m_instrs, m_cycles);
        end
`endif
        Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = alf;
        build(c, op, f, rd, alf);
        n = (stop_after > 0 && stop_after < seq.size()) ? stop_after : seq.size();
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
        repeat (n) begin @(posedge clk); #1; end
`ifdef PERF_CNT_EN
        m_cycles += n;
        if (n == seq.size()) m_instrs++;
`endif
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b1;
        mflags = 4'b0000;
        repeat (cycles) begin @(posedge clk); #1; end
        reset = 1'b0;
`ifdef PERF_CNT_EN
        m_cycles = 0;
        m_instrs = 0;
`endif
    endtask

    // Monitor: every falling edge is one observed cycle.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            a = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
                 ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
            checks++;
            if (reset) begin
                e = rec(Op, 2'b01, 2'b10, 2'b10);
                if (a !== e) begin
                    errors++;
                    $display("FAIL reset_obs actual=%b required=%b", a, e);
                end
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cycle actual=%b required=<none>", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_obs t=%0t actual=%b required=%b", $time, a, e);
                end
            end
        end
    end

    initial begin
        logic [1:0] op;
        logic [3:0] rd;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 0); // BEQ not taken: flags clear
        run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b1111, 0); // ADD R1,R2,R3
        run_instr(4'b1110, 2'b00, 6'b000101, 4'd4, 4'b0100, 0); // SUBS -> Z=1
        run_instr(4'b0000, 2'b10, 6'b101010, 4'd0, 4'b0000, 0); // BEQ taken
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000, 0); // LDR
        run_instr(4'b0001, 2'b01, 6'b011000, 4'd3, 4'b0000, 0); // STRNE, suppressed
        run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 0); // BEQ still taken
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000, 3); // LDR cut in MEMRD
        pulse_reset(1);
        run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 0); // flags cleared again
        run_instr(4'b1111, 2'b11, 6'b111111, 4'd15, 4'b1111, 0);
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd15, 4'b1010, 0); // ADDS PC, immediate

        for (int k = 0; k < 300; k++) begin
            op = 2'($urandom_range(0, 3));
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                run_instr(4'($urandom_range(0, 15)), op, 6'($urandom), rd, 4'($urandom),
                          $urandom_range(1, 2));
                pulse_reset($urandom_range(1, 2));
            end else begin
                run_instr(4'($urandom_range(0, 15)), op, 6'($urandom), rd, 4'($urandom), 0);
            end
        end

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain remaining=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
